// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the instruction fetch front-end
//
// Purpose: default instruction width, fetch-address alignment, and the width
// rule for the occupancy counters used by fetch_unit and fetch_fifo.
// Ports: none (package).

package fetch_pkg;

    // Default instruction word width.
    localparam int INSTR_WIDTH_DEF = 32;

    // Fetches are word aligned: the two LSBs of every fetch address are zero.
    localparam int ALIGN_BITS = 2;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int ctr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous circular FIFO with flush, used for pc tags and instructions
//
// Purpose: DEPTH-entry first-in first-out store. Head data is shown
// combinationally on pop_data; a pop advances the read pointer.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   flush      in   empty the FIFO; overrides push and pop in the same cycle
//   push       in   write push_data at the tail (ignored while full)
//   push_data  in   WIDTH-bit entry to write
//   pop        in   remove the head entry (ignored while empty)
//   pop_data   out  WIDTH-bit head entry; undefined while empty
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = ctr_width(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage has no reset; only entries below cnt are ever read as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch front-end with prefetch queue and redirect flush
//
// Purpose: issues word fetches on a valid/ready request channel, accepts
// in-order responses of arbitrary latency, and buffers {pc, instr} pairs in a
// prefetch queue. A redirect flushes the queue, retargets the fetch pc, and
// arranges for every response still in flight to be discarded.
// Ports:
//   sysclk          in   clock, rising edge
//   rst             in   synchronous active-high reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  word-aligned fetch byte address
//   imem_rsp_valid  in   response word valid (request order)
//   imem_rsp_data   in   response instruction word
//   instr_valid     out  queue head valid
//   instr_ready     in   decode consumes the head
//   instr_data      out  head instruction word
//   instr_pc        out  head instruction address
//   redirect_valid  in   branch/jump taken: flush and refetch
//   redirect_pc     in   new fetch address (two LSBs ignored)

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                  DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   sysclk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc
);

    localparam int CW = ctr_width(DEPTH);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       in_flight;
    logic [CW-1:0]       count;
    logic [CW:0]         credit_used;

    logic                req_fire;
    logic                rsp_take;
    logic                q_push;
    logic                q_pop;

    logic [PC_WIDTH-1:0] tag_head;
    logic                tag_full;
    logic                tag_empty;

    logic [EW-1:0]       q_head;
    logic                q_full;
    logic                q_empty;

    logic                unused_bits;

    // Every outstanding request owns exactly one tag, so the tag queue's
    // occupancy is the in-flight count, doomed requests included.
    // Credit check: outstanding plus buffered never exceeds DEPTH, which is
    // what lets the instruction queue accept every response unconditionally.
    assign credit_used    = {1'b0, in_flight} + {1'b0, count};
    assign imem_req_valid = !rst && !redirect_valid && !tag_full
                            && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response always retires its tag, whether it is kept or discarded.
    assign rsp_take = imem_rsp_valid && !tag_empty;
    assign q_push   = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign q_pop    = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !rst && !q_empty;
    assign {instr_pc, instr_data} = q_head;

    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (sysclk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_take),
        .pop_data  (tag_head),
        .count     (in_flight),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (sysclk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Fetch pc: reset, redirect (aligned), or advance one word per accepted
    // request. The addition wraps modulo 2^PC_WIDTH.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            fetch_pc <= {RESET_PC[PC_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[PC_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(4);
        end
    end

    // Discard counter: on redirect, everything still outstanding after this
    // cycle's response becomes stale. A back-to-back redirect reloads from the
    // same in-flight count, which already covers the earlier doomed requests.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= in_flight - CW'(rsp_take);
        end else if (rsp_take && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // The queue can never be full on a push, and the alignment bits of the
    // redirect target are deliberately ignored.
    assign unused_bits = ^{q_full, redirect_pc[ALIGN_BITS-1:0]};

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch front-end for the next-generation core. It replaces the fixed PC-register-plus-synchronous-program-memory arrangement with a decoupled unit. The unit issues word fetches over a valid/ready request channel, accepts in-order responses after arbitrary latency, and buffers instructions in a prefetch queue. Branch/jump redirects from execute flush the queue and discard stale in-flight responses.

## Interface
Parameters:
- PC_WIDTH, 16, byte-address width of the PC; fetch addresses wrap modulo 2^PC_WIDTH.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, prefetch queue depth and maximum outstanding-plus-buffered fetches; power of two, ≥ 2.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- sysclk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  PC_WIDTH  byte address of the fetch; bits [1:0] always 0.
- imem_rsp_valid  in  1  response word valid; responses return in request order.
- imem_rsp_data  in  INSTR_WIDTH  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode consumes the head this cycle.
- instr_data  out  INSTR_WIDTH  head instruction.
- instr_pc  out  PC_WIDTH  address of the head instruction.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  PC_WIDTH  new fetch address; bits [1:0] ignored (treated as 0).

## Operation
- State: fetch_pc, in_flight counter, drop_cnt counter, queue of {pc, instr} entries, count. Counters are $clog2(DEPTH+1) bits wide.
- Request: imem_req_valid = !rst && !redirect_valid && (in_flight + count < DEPTH). imem_req_addr = fetch_pc.
- On a request handshake: fetch_pc += 4 (wraps at 2^PC_WIDTH), in_flight increments, and fetch_pc is pushed to the internal pc-tag queue.
- Response: in_flight decrements.
  - If drop_cnt > 0, the word is discarded and drop_cnt decrements.
  - Otherwise the word is pushed with its pc tag.
- Pop: instr_valid && instr_ready removes the head.
- Redirect (highest priority), applied in the cycle redirect_valid is high:
  - the queue is cleared;
  - any pop that cycle is ignored;
  - a response arriving that cycle is discarded;
  - drop_cnt ← in_flight after this cycle's decrement;
  - fetch_pc ← {redirect_pc[PC_WIDTH-1:2], 2'b00};
  - no request is issued that cycle.
- Back-to-back redirects: each one reloads drop_cnt from the current in_flight. in_flight counts every outstanding request, including doomed ones, so discards never under- or over-count.
- Full: the credit check guarantees a queue push never overflows. A response must always be accepted; there is no rsp backpressure.
- Empty: instr_valid = 0. instr_data and instr_pc are don't-care.
- Simultaneous push and pop with count = DEPTH cannot occur by construction. With 0 < count < DEPTH, count is unchanged.

## Timing
- Reset values:
  - imem_req_valid = 0 and instr_valid = 0 while rst is high.
  - fetch_pc = RESET_PC; in_flight = drop_cnt = count = 0.
  - Reset mid-operation abandons all state. Responses to pre-reset requests must not be delivered afterwards; the memory is reset with the same rst.
- First request is presented in the first cycle after rst falls.
- Response-to-instr_valid latency is 1 cycle: the registered queue has no bypass. A request accepted in cycle N with memory latency L gives instr_valid in cycle N+L+1.
- Redirect in cycle R: the flush takes effect in R+1, where instr_valid = 0 and the request with addr = redirect_pc is presented.
- Sustained throughput is one instruction per cycle when L+1 < DEPTH.

## Structure
- Package fetch_pkg: instruction word width default and the alignment constant (2 LSBs).
- Sub-module fetch_fifo: a synchronous FIFO parametrised by width and depth, with flush, push, pop, count, full and empty. It is instantiated twice, once as the pc-tag queue and once as the instruction queue (or once with a combined {pc, instr} entry). Entries are pushed on request and written on response.

## Test plan
- Reset release, memory with L=1, instr_ready=1 -> requests 0x0, 0x4, 0x8, …; first instr_valid 3 cycles after rst falls; instr_pc tracks the addresses.
- instr_ready=0, DEPTH=4 -> exactly 4 handshakes, then imem_req_valid=0; count=4; no data lost once ready returns.
- L=3 with 3 in flight, redirect_pc=0x103 -> next 3 responses discarded; next head has instr_pc=0x100 with the data of that fetch.
- Redirect, then a second redirect 1 cycle later to 0x40 -> only fetches from 0x40 onward are delivered; no stale word appears.
- PC_WIDTH=8, fetch_pc=0xFC -> next request addr is 0x00.
- rst asserted mid-stream with queue full -> next cycle instr_valid=0; first post-reset request at RESET_PC.
